bit_sync_edge_filter: RTL
=========================

Name: bit_sync_edge_filter

Overview:
Parametrised multi-channel input conditioner for asynchronous level signals, such as buttons, external status pins and cross-domain flags, entering the CLK domain.
- Each channel passes through an N-stage synchronizer chain.
- It then goes through an optional per-channel stability (glitch/debounce) filter.
- Outputs are the filtered level plus one-cycle rise/fall strobes.
- Sits at chip/subsystem boundary in place of plain bit synchronizers wherever downstream logic needs clean edges.

Parameters:
BUS_WIDTH, 4, number of independent channels (>=1)
NUM_STAGES, 2, synchronizer flops per channel (>=2)
FILT_CYCLES, 4, consecutive cycles a new synchronized value must persist before acceptance (>=1)
CNT_W, derived = clog2(FILT_CYCLES+1), per-channel filter counter width (localparam, not overridable)

Ports:
CLK  input  1  destination clock; all logic on rising edge
rst_n  input  1  reset, synchronous and active-low
Async  input  BUS_WIDTH  asynchronous level inputs, one per channel
Filt_En  input  1  1 = stability filter active; 0 = bypass filter (CLK-domain signal)
Sync  output  BUS_WIDTH  filtered synchronized level (registered)
Rise_Pulse  output  BUS_WIDTH  one-cycle strobe when Sync[i] goes 0->1
Fall_Pulse  output  BUS_WIDTH  one-cycle strobe when Sync[i] goes 1->0
Any_Edge  output  1  OR-reduction of Rise_Pulse|Fall_Pulse (combinational from registered pulses)

Behaviour:
- Reset: rst_n low sampled at a CLK rising edge clears every sync stage, every counter, Sync, Rise_Pulse and Fall_Pulse to 0; Any_Edge therefore 0.
  - Reset is synchronous only; no asynchronous clear path.
  - Reset asserted mid-count aborts the count; pending pulses are dropped.
- Sync chain, per channel i: stage[0] <= Async[i]; stage[k] <= stage[k-1]. raw[i] = stage[NUM_STAGES-1].
  - Only stage[0] may sample Async.
  - No combinational logic between stages.
- Filter, Filt_En=1, per channel:
  - raw==Sync: cnt <= 0.
  - raw!=Sync and cnt < FILT_CYCLES-1: cnt <= cnt+1.
  - raw!=Sync and cnt == FILT_CYCLES-1: Sync <= raw, cnt <= 0, matching pulse <= 1.
  - Any return of raw to Sync before acceptance resets cnt; glitches shorter than FILT_CYCLES cycles at raw are fully rejected.
- Bypass, Filt_En=0: Sync <= raw each cycle; cnt held at 0; pulses still generated on every Sync change.
- Filt_En change mid-count: falling to 0 clears cnt and the next edge follows bypass rule. Rising to 1 starts counting from 0.
- Latency, Async stable from before edge 1:
  - Filtered: Sync and pulse update at edge NUM_STAGES+FILT_CYCLES.
  - Bypass: update at edge NUM_STAGES+1.
- Pulses: registered, exactly one cycle wide, asserted the same cycle Sync changes. Rise_Pulse and Fall_Pulse of the same channel are never both 1.
- Channels are fully independent; simultaneous events on several channels each produce their own pulse in the same cycle.
- After reset release with Async[i]=1: Sync[i] rises after the normal latency and Rise_Pulse[i] fires once, because the reset value is 0.
- Counter never exceeds FILT_CYCLES-1; no wrap-around possible.
- Multi-bit buses are NOT coherent across channels; each bit is synchronized independently. Gray-coded or handshake transfer is the user's responsibility.

Decomposition:
- Shared package lpcs_sync_pkg:
  - clog2 constant function.
  - MIN_SYNC_STAGES=2 constant, checked by elaboration-time assertion on NUM_STAGES.
  - FILT_CYCLES>=1 assertion.
- One sub-module, sync_filt_chan: single-channel sync chain + counter + pulse logic.
  - Parameters NUM_STAGES, FILT_CYCLES.
  - Instantiated BUS_WIDTH times in a generate loop.
- Top level adds only the Any_Edge reduction.

Test Plan:
1. BUS_WIDTH=4, NUM_STAGES=2, FILT_CYCLES=4, Filt_En=1; Async 0000->0001 before edge 1, held. Required: Sync=0001 and Rise_Pulse=0001 at edge 6; Rise_Pulse=0000 at edge 7; Any_Edge high one cycle.
2. Glitch reject: Async[2]=1 for 3 cycles then 0. Required: Sync stays 0000, no pulses. Repeat with 4-cycle high: Sync[2] rises, then falls 4 cycles after raw returns low, with one Rise_Pulse[2] and one Fall_Pulse[2].
3. Bypass: Filt_En=0, Async 0000->1010. Required: Sync=1010 and Rise_Pulse=1010 at edge 3. Then Async->0000 gives Fall_Pulse=1010 three edges later.
4. Reset mid-count: Async=1111 held, rst_n low at edge 4 for 2 cycles. Required: all outputs 0 during reset. Sync=1111 at edge 6 after release, counting edges from the first edge with rst_n high; one Rise_Pulse per channel.
5. Simultaneous/independent: Async[0] rises and Async[3] falls (from settled 1000) in the same cycle. Required: Rise_Pulse=0001 and Fall_Pulse=1000 in the same cycle; never both set on one channel.
6. Filt_En dropped at edge 4 of a count (Async[1] toggled). Required: cnt cleared; Sync[1] follows raw at edge 5 in bypass; exactly one pulse.

Source files
------------

// File: rtl/bit_sync_edge_filter_pkg.sv
// Shared constants and helpers for the synchronizer/edge-filter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lpcs_sync_pkg;

  // A single flop gives no metastability settling time, so two is the floor.
  localparam int MIN_SYNC_STAGES = 2;

  // Ceiling log2, usable in constant expressions for counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bit_sync_edge_filter_chan.sv
// Single channel: NUM_STAGES-flop synchronizer, stability counter, rise/fall strobes.
// Latency: NUM_STAGES+FILT_CYCLES edges filtered, NUM_STAGES+1 edges in bypass.
// Backpressure: none; free-running level path, pulses are one cycle and never held.
module sync_filt_chan
  import lpcs_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_lvl,
  input  logic filt_en,
  output logic sync_lvl,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [NUM_STAGES-1:0] stages;
  logic [CNT_W-1:0]      cnt;
  logic                  raw;

  assign raw = stages[NUM_STAGES-1];

  // Plain shift chain: only stages[0] sees the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[NUM_STAGES-2:0], async_lvl};
    end
  end

  // Accept a new level only after it has persisted; pulses mark each accepted change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      sync_lvl <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!filt_en) begin
        // Bypass: follow raw directly and keep the counter parked at zero.
        cnt <= '0;
        if (raw != sync_lvl) begin
          sync_lvl <= raw;
          rise     <= raw;
          fall     <= ~raw;
        end
      end else if (raw == sync_lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sync_lvl <= raw;
        cnt      <= '0;
        rise     <= raw;
        fall     <= ~raw;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bit_sync_edge_filter.sv
// Multi-channel async level conditioner: per-bit sync + debounce + edge strobes.
// Latency: NUM_STAGES+FILT_CYCLES edges filtered, NUM_STAGES+1 edges in bypass.
// Backpressure: none; channels are independent and not coherent with each other.
module bit_sync_edge_filter
  import lpcs_sync_pkg::*;
#(
  parameter int BUS_WIDTH   = 4,
  parameter int NUM_STAGES  = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] Async,
  input  logic                 Filt_En,
  output logic [BUS_WIDTH-1:0] Sync,
  output logic [BUS_WIDTH-1:0] Rise_Pulse,
  output logic [BUS_WIDTH-1:0] Fall_Pulse,
  output logic                 Any_Edge
);

  // Reject parameterisations that would break synchronization or the counter.
  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_chk_stages
    $error("NUM_STAGES must be at least MIN_SYNC_STAGES");
  end
  if (FILT_CYCLES < 1) begin : g_chk_filt
    $error("FILT_CYCLES must be at least 1");
  end

  // One independent conditioner per bit.
  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
    sync_filt_chan #(
      .NUM_STAGES (NUM_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_chan (
      .clk      (CLK),
      .rst_n    (rst_n),
      .async_lvl(Async[i]),
      .filt_en  (Filt_En),
      .sync_lvl (Sync[i]),
      .rise     (Rise_Pulse[i]),
      .fall     (Fall_Pulse[i])
    );
  end

  // Summary strobe derived from the registered pulses.
  assign Any_Edge = |(Rise_Pulse | Fall_Pulse);

endmodule
